// File: rtl/step_sequencer12.sv
// -----------------------------------------------------------------------------
// step_sequencer12
// Tempo-driven 12-step sequencer. Converts the system clock into step advances
// at a programmable tempo and produces the 4-bit step select for the
// downstream 12-way pad-data mux.
//
// Ports:
//   CLK       in   system clock, rising edge active
//   RSTn      in   asynchronous active-low reset
//   Start     in   one-cycle pulse: start/restart at step 0
//   Stop      in   one-cycle pulse: abort and return to idle
//   Pause     in   level: freeze playback while high
//   LoopEn    in   level: 1 = wrap after LAST_STEP, 0 = one-shot
//   TempoSel  in   ticks per step minus one
//   Sin       out  current step index (0..LAST_STEP)
//   StepStb   out  pulse in the cycle Sin takes a new step value
//   Running   out  high while playing or paused
//   Done      out  pulse when a one-shot pass completes
// -----------------------------------------------------------------------------
module step_sequencer12 #(
    parameter int TICK_DIV  = 50000,
    parameter int LAST_STEP = 11
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Pause,
    input  logic       LoopEn,
    input  logic [3:0] TempoSel,
    output logic [3:0] Sin,
    output logic       StepStb,
    output logic       Running,
    output logic       Done
);

    localparam int             PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRE_ONE = PW'(1'b1);
    localparam logic [PW-1:0]  PRE_ZERO = {PW{1'b0}};
    localparam logic [3:0]     LAST_S  = 4'(LAST_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;

    logic [PW-1:0]  pre_cnt_r;
    logic [PW-1:0]  pre_cnt_nxt_s;
    logic [3:0]     tick_cnt_r;
    logic [3:0]     tick_cnt_nxt_s;
    logic [3:0]     tempo_lat_r;
    logic [3:0]     tempo_lat_nxt_s;
    logic [3:0]     sin_r;
    logic [3:0]     sin_nxt_s;
    logic           step_stb_r;
    logic           step_stb_nxt_s;
    logic           running_r;
    logic           running_nxt_s;
    logic           done_r;
    logic           done_nxt_s;

    logic           tick_s;
    logic           adv_cond_s;
    logic           count_en_s;
    logic           advance_s;
    logic           finish_s;

    // Prescaler tick, step-advance decision and counting enable.
    always_comb begin
        tick_s     = (pre_cnt_r == PRE_MAX);
        adv_cond_s = tick_s && (tick_cnt_r == tempo_lat_r);
        // A step advance outranks Pause in RUN; otherwise Pause freezes the
        // counters. The resume cycle (PAUSE with Pause low) already counts, so
        // the remaining step time after release equals what was left.
        if (state_r == ST_IDLE) begin
            count_en_s = 1'b0;
        end else if (!Pause) begin
            count_en_s = 1'b1;
        end else begin
            count_en_s = (state_r == ST_RUN) && adv_cond_s;
        end
        advance_s = count_en_s && adv_cond_s;
        finish_s  = advance_s && (sin_r == LAST_S) && !LoopEn;
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: Stop > Start > step advance > Pause.
    always_comb begin
        state_nxt_s = state_r;
        if (Stop) begin
            state_nxt_s = ST_IDLE;
        end else if (Start) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_RUN: begin
                    if (finish_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (Pause && !advance_s) begin
                        state_nxt_s = ST_PAUSE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (Pause) begin
                        state_nxt_s = ST_PAUSE;
                    end else if (finish_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Next values of counters and registered outputs.
    always_comb begin
        pre_cnt_nxt_s   = pre_cnt_r;
        tick_cnt_nxt_s  = tick_cnt_r;
        tempo_lat_nxt_s = tempo_lat_r;
        sin_nxt_s       = sin_r;
        step_stb_nxt_s  = 1'b0;
        done_nxt_s      = 1'b0;
        if (Stop) begin
            pre_cnt_nxt_s   = PRE_ZERO;
            tick_cnt_nxt_s  = 4'd0;
            tempo_lat_nxt_s = 4'd0;
            sin_nxt_s       = 4'd0;
        end else if (Start) begin
            pre_cnt_nxt_s   = PRE_ZERO;
            tick_cnt_nxt_s  = 4'd0;
            tempo_lat_nxt_s = TempoSel;
            sin_nxt_s       = 4'd0;
            step_stb_nxt_s  = 1'b1;
        end else if (count_en_s) begin
            if (tick_s) begin
                pre_cnt_nxt_s = PRE_ZERO;
                if (adv_cond_s) begin
                    // Step boundary: the new tempo only applies from here on.
                    tick_cnt_nxt_s  = 4'd0;
                    tempo_lat_nxt_s = TempoSel;
                    if (sin_r != LAST_S) begin
                        sin_nxt_s      = sin_r + 4'd1;
                        step_stb_nxt_s = 1'b1;
                    end else if (LoopEn) begin
                        sin_nxt_s      = 4'd0;
                        step_stb_nxt_s = 1'b1;
                    end else begin
                        sin_nxt_s  = 4'd0;
                        done_nxt_s = 1'b1;
                    end
                end else begin
                    tick_cnt_nxt_s = tick_cnt_r + 4'd1;
                end
            end else begin
                pre_cnt_nxt_s = pre_cnt_r + PRE_ONE;
            end
        end else if (state_r == ST_IDLE) begin
            pre_cnt_nxt_s = PRE_ZERO;
        end else begin
            pre_cnt_nxt_s = pre_cnt_r;
        end
        running_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Counter and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre_cnt_r   <= PRE_ZERO;
            tick_cnt_r  <= 4'd0;
            tempo_lat_r <= 4'd0;
            sin_r       <= 4'd0;
            step_stb_r  <= 1'b0;
            running_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            pre_cnt_r   <= pre_cnt_nxt_s;
            tick_cnt_r  <= tick_cnt_nxt_s;
            tempo_lat_r <= tempo_lat_nxt_s;
            sin_r       <= sin_nxt_s;
            step_stb_r  <= step_stb_nxt_s;
            running_r   <= running_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign Sin     = sin_r;
    assign StepStb = step_stb_r;
    assign Running = running_r;
    assign Done    = done_r;

endmodule

// File: tb/tb_step_sequencer12.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer12
// Directed bench for step_sequencer12 (TICK_DIV=4, LAST_STEP=11). Expected
// step/done pulses are queued with their cycle numbers when stimulus is
// driven, and popped and compared whenever the DUT pulses.
// -----------------------------------------------------------------------------
module tb_step_sequencer12;

    logic       CLK;
    logic       RSTn;
    logic       Start;
    logic       Stop;
    logic       Pause;
    logic       LoopEn;
    logic [3:0] TempoSel;
    logic [3:0] Sin;
    logic       StepStb;
    logic       Running;
    logic       Done;

    step_sequencer12 #(
        .TICK_DIV  (4),
        .LAST_STEP (11)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .Start    (Start),
        .Stop     (Stop),
        .Pause    (Pause),
        .LoopEn   (LoopEn),
        .TempoSel (TempoSel),
        .Sin      (Sin),
        .StepStb  (StepStb),
        .Running  (Running),
        .Done     (Done)
    );

    typedef struct {
        int         cyc;
        logic [3:0] sin;
        logic       done;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  c0;
    int  t4;
    int  p0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle number of the most recent rising edge.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int c, input int s, input logic d);
        ev_t e;
        e.cyc  = c;
        e.sin  = 4'(s);
        e.done = d;
        q.push_back(e);
    endfunction

    task automatic monitor();
        ev_t e;
        if (StepStb || Done) begin
            if (q.size() == 0) begin
                check("spurious_pulse", 32'({StepStb, Done}), 32'd0);
            end else begin
                e = q.pop_front();
                check("ev_cycle",   32'(cyc),      32'(e.cyc));
                check("ev_sin",     32'(Sin),      32'(e.sin));
                check("ev_done",    32'(Done),     32'(e.done));
                check("ev_stb",     32'(StepStb),  32'(!e.done));
                check("ev_running", 32'(Running),  32'(!e.done));
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            check("missed_pulse", 32'(StepStb), 32'd1);
            void'(q.pop_front());
        end
        check("inv_stb_done", 32'(StepStb & Done), 32'd0);
        check("inv_idle_sin", 32'(!Running && (Sin != 4'd0)), 32'd0);
        check("inv_sin_range", 32'(Sin > 4'd11), 32'd0);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            monitor();
        end
    endtask

    task automatic pulse(input logic s_start, input logic s_stop);
        Start = s_start;
        Stop  = s_stop;
        run_cycles(1);
        Start = 1'b0;
        Stop  = 1'b0;
    endtask

    initial begin
        RSTn     = 1'b0;
        Start    = 1'b0;
        Stop     = 1'b0;
        Pause    = 1'b0;
        LoopEn   = 1'b1;
        TempoSel = 4'd1;

        // Reset state, then 100 idle cycles with no pulses.
        run_cycles(3);
        check("rst_sin",     32'(Sin),     32'd0);
        check("rst_stb",     32'(StepStb), 32'd0);
        check("rst_running", 32'(Running), 32'd0);
        check("rst_done",    32'(Done),    32'd0);
        RSTn = 1'b1;
        Pause = 1'b1;
        pulse(1'b0, 1'b1);
        run_cycles(100);
        Pause = 1'b0;
        check("idle_sin",     32'(Sin),     32'd0);
        check("idle_running", 32'(Running), 32'd0);

        // Basic loop: 8-cycle steps, wrap 11 -> 0 carries a strobe.
        TempoSel = 4'd1;
        LoopEn   = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 14; i++) push(c0 + 1 + 8 * i, i % 12, 1'b0);
        pulse(1'b1, 1'b0);
        check("loop_running", 32'(Running), 32'd1);
        run_cycles(105);
        pulse(1'b0, 1'b1);
        check("stop_sin",     32'(Sin),     32'd0);
        check("stop_running", 32'(Running), 32'd0);

        // One-shot: 4-cycle steps, Done after step 11, then silence.
        TempoSel = 4'd0;
        LoopEn   = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 12; i++) push(c0 + 1 + 4 * i, i, 1'b0);
        push(c0 + 49, 0, 1'b1);
        pulse(1'b1, 1'b0);
        run_cycles(58);
        check("oneshot_running", 32'(Running), 32'd0);
        check("oneshot_sin",     32'(Sin),     32'd0);

        // Pause 3 cycles into step 4 for 20 cycles; step 5 follows 5 cycles
        // after release.
        TempoSel = 4'd1;
        LoopEn   = 1'b1;
        c0 = cyc;
        t4 = c0 + 33;
        for (int i = 0; i < 5; i++) push(c0 + 1 + 8 * i, i, 1'b0);
        pulse(1'b1, 1'b0);
        run_cycles(t4 + 3 - cyc);
        Pause = 1'b1;
        run_cycles(20);
        check("pause_sin",     32'(Sin),     32'd4);
        check("pause_running", 32'(Running), 32'd1);
        Pause = 1'b0;
        push(t4 + 28, 5, 1'b0);
        push(t4 + 36, 6, 1'b0);
        push(t4 + 44, 7, 1'b0);
        run_cycles(t4 + 46 - cyc);
        Pause = 1'b1;
        run_cycles(5);
        check("pause7_sin", 32'(Sin), 32'd7);

        // Start during PAUSE at step 7 restarts from step 0 in RUN.
        Pause = 1'b0;
        p0 = cyc;
        push(p0 + 1, 0, 1'b0);
        push(p0 + 9, 1, 1'b0);
        pulse(1'b1, 1'b0);
        check("restart_running", 32'(Running), 32'd1);
        run_cycles(10);

        // Start and Stop together: Stop wins.
        pulse(1'b1, 1'b1);
        check("startstop_sin",     32'(Sin),     32'd0);
        check("startstop_running", 32'(Running), 32'd0);
        run_cycles(20);

        // Tempo change mid step 2: step 2 keeps 8 cycles, step 3 on is 16.
        TempoSel = 4'd1;
        LoopEn   = 1'b1;
        c0 = cyc;
        push(c0 + 1,  0, 1'b0);
        push(c0 + 9,  1, 1'b0);
        push(c0 + 17, 2, 1'b0);
        push(c0 + 25, 3, 1'b0);
        push(c0 + 41, 4, 1'b0);
        push(c0 + 57, 5, 1'b0);
        pulse(1'b1, 1'b0);
        run_cycles(c0 + 20 - cyc);
        TempoSel = 4'd3;
        run_cycles(c0 + 60 - cyc);
        pulse(1'b0, 1'b1);

        // Asynchronous reset while at step 5.
        TempoSel = 4'd0;
        c0 = cyc;
        for (int i = 0; i < 6; i++) push(c0 + 1 + 4 * i, i, 1'b0);
        pulse(1'b1, 1'b0);
        run_cycles(c0 + 22 - cyc);
        check("pre_rst_sin", 32'(Sin), 32'd5);
        #2;
        RSTn = 1'b0;
        #1;
        check("async_rst_sin",     32'(Sin),     32'd0);
        check("async_rst_running", 32'(Running), 32'd0);
        check("async_rst_stb",     32'(StepStb), 32'd0);
        check("async_rst_done",    32'(Done),    32'd0);
        run_cycles(3);
        RSTn = 1'b1;
        run_cycles(20);
        check("post_rst_sin",     32'(Sin),     32'd0);
        check("post_rst_running", 32'(Running), 32'd0);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_sequencer12.md
Name: step_sequencer12

Overview:
- Tempo-driven 12-step sequencer. Generates the 4-bit step select (Sin) that drives the downstream 12-way, 4-bit pad-data mux (Mux12_4_4).
- Sits directly upstream of that mux. Converts the system clock into step advances at a programmable tempo.
- Supports play, pause, stop, restart, and loop or one-shot playback.

Parameters:
- TICK_DIV, 50000: clock cycles per tempo tick (>= 2). Benches use 4.
- LAST_STEP, 11: index of the final step. Steps run 0..LAST_STEP. LAST_STEP must be <= 15.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RSTn  in  1  reset; asynchronous assert, active-low.
- Start  in  1  one-cycle pulse: begin/restart playback at step 0.
- Stop  in  1  one-cycle pulse: abort playback and return to idle.
- Pause  in  1  level: freeze playback while high (RUN only).
- LoopEn  in  1  level: 1 = wrap after LAST_STEP; 0 = one-shot.
- TempoSel  in  4  ticks per step minus one. Step length = TICK_DIV*(TempoSel+1) cycles.
- Sin  out  4  current step index to mux select; always 0..LAST_STEP.
- StepStb  out  1  one-cycle pulse in the cycle Sin takes a new step value.
- Running  out  1  high in RUN or PAUSE.
- Done  out  1  one-cycle pulse when a one-shot pass completes.

Behaviour:
- Reset (RSTn=0, async): state IDLE; Sin=0, StepStb=0, Running=0, Done=0; PreCnt=0, TickCnt=0, TempoLat=0.
- All outputs are registered.
- States and transitions:
  - IDLE -> RUN on Start.
  - RUN -> PAUSE when Pause=1 and no Start/Stop that cycle.
  - PAUSE -> RUN when Pause=0.
  - any state -> IDLE on Stop.
  - RUN -> IDLE at end of a one-shot pass.
- Priority when several events occur in one cycle: Stop > Start > step advance > Pause.
- Start, from any state (no Stop that cycle):
  - Next cycle: Sin=0, StepStb=1, Running=1, state RUN.
  - PreCnt=0, TickCnt=0, TempoLat=TempoSel.
  - A Start during RUN or PAUSE is a restart from step 0.
- Prescaler:
  - PreCnt counts 0..TICK_DIV-1 only in RUN.
  - Tick is asserted internally when PreCnt==TICK_DIV-1; PreCnt wraps to 0 on that cycle.
  - PreCnt holds in PAUSE and is held at 0 in IDLE.
- Step advance:
  - On a Tick with TickCnt==TempoLat: TickCnt=0, TempoLat reloads from TempoSel, and the step updates as below.
  - On any other Tick: TickCnt+1.
  - TempoSel changes take effect only at a step boundary or on Start. The step in progress keeps its length.
- Step update on advance:
  - Sin<LAST_STEP: Sin+1, StepStb=1.
  - Sin==LAST_STEP with LoopEn=1: Sin=0, StepStb=1 (wrap).
  - Sin==LAST_STEP with LoopEn=0: state IDLE, Sin=0, Done=1, Running=0, StepStb=0.
- LoopEn is sampled at the wrap decision only.
- Latency: first step change after Start occurs exactly TICK_DIV*(TempoLat+1) cycles after the StepStb that accompanied step 0.
- Pause:
  - The cycle Pause rises, no counter advances.
  - On resume, the remaining step time is exactly what remained at pause; no tick is lost or duplicated.
  - StepStb never fires in PAUSE. Pause is ignored in IDLE.
- Stop:
  - Next cycle: IDLE, Sin=0, Running=0, StepStb=0, Done=0, counters cleared.
  - Stop in IDLE is harmless (no pulses).
- Reset mid-operation aborts immediately to reset values; no Done is generated.
- Invariants:
  - Sin never leaves 0..LAST_STEP.
  - StepStb and Done are never high in the same cycle.
  - Running=0 implies Sin=0.

Test Plan:
- Reset/idle: assert RSTn=0 mid-RUN at Sin=5 -> Sin=0, Running=0, StepStb=0 asynchronously. With RSTn=1 and no Start for 100 cycles -> Sin stays 0, no strobes.
- Basic loop (TICK_DIV=4, TempoSel=1, LoopEn=1): Start pulse -> Sin=0 with StepStb next cycle, then Sin 1,2,...,11,0,1 with each step lasting 8 cycles. The wrap 11->0 carries StepStb.
- One-shot (LoopEn=0, TempoSel=0): Start -> steps 0..11 at 4 cycles each. The advance after step 11 gives Done=1 for one cycle, Sin=0, Running=0. No further StepStb.
- Pause: Pause=1 for 20 cycles starting 3 cycles into step 4 (TempoSel=1) -> Sin holds 4, no StepStb. After release, step 5 arrives 5 cycles later (8-3).
- Tempo change: change TempoSel 1->3 mid-step 2 -> step 2 still lasts 8 cycles; step 3 onward lasts 16 cycles.
- Simultaneous events: Start and Stop in the same cycle during RUN -> IDLE, Sin=0. Start during PAUSE at Sin=7 -> Sin=0 with StepStb, state RUN with Pause=0.
